// File: rtl/light_hash_pkg.sv
// rtl/light_hash_pkg.sv - shared constants, FSM states and byte helpers for light_hash_stream
package light_hash_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_OUT
   } state_t;

   localparam logic [0:7][7:0] IV8 = 64'h34550F14DAC02BEE;

   function automatic logic [7:0] rotl8(input logic [7:0] x, input int unsigned s);
      logic [15:0] d;
      d = {x, x} << (s % 8);
      return d[15:8];
   endfunction

   // Digests wider than 8 bytes reuse IV8, tweaked by the 8-byte block index.
   function automatic logic [7:0] iv_byte(input int unsigned i);
      return IV8[3'(i % 8)] ^ 8'(i / 8);
   endfunction

endpackage

// File: rtl/lh_aes_sbox.sv
// rtl/lh_aes_sbox.sv - combinational AES forward S-box
module lh_aes_sbox (
   input  logic [7:0] a,
   output logic [7:0] y
);

   localparam logic [0:255][7:0] TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   assign y = TABLE[a];

endmodule

// File: rtl/light_hash_stream.sv
// rtl/light_hash_stream.sv - multi-cycle byte-stream hash with RPC-way unrolled S-box rounds
module light_hash_stream
   import light_hash_pkg::*;
#(
   parameter int N_BYTES = 8,
   parameter int ROUNDS  = 32,
   parameter int RPC     = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clear,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [7:0]             in_data,
   input  logic                   in_first,
   input  logic                   in_last,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [8*N_BYTES-1:0]   out_digest,
   output logic                   busy
);

   localparam int CW = $clog2(ROUNDS + 1);

   function automatic logic [8*N_BYTES-1:0] iv_init();
      logic [8*N_BYTES-1:0] v;
      v = '0;
      for (int i = 0; i < N_BYTES; i++) v[8*(N_BYTES-1-i) +: 8] = iv_byte(i);
      return v;
   endfunction

   localparam logic [8*N_BYTES-1:0] IV = iv_init();

   state_t                 state, state_nxt;
   logic [8*N_BYTES-1:0]   h;
   logic [7:0]             m;
   logic                   last;
   logic [CW-1:0]          cnt;
   logic                   accept;
   logic                   final_round;
   logic [8*N_BYTES-1:0]   round_out;

   // H[0] lives in the MSBs so the register doubles as the digest word.
   for (genvar k = 0; k < RPC; k++) begin : g_rnd
      logic [8*N_BYTES-1:0] src;
      logic [8*N_BYTES-1:0] res;
      if (k == 0) begin : g_first
         assign src = h;
      end else begin : g_next
         assign src = g_rnd[k-1].res;
      end
      for (genvar j = 0; j < N_BYTES; j++) begin : g_byte
         logic [7:0] sin;
         assign sin = rotl8(src[8*(N_BYTES-1-((j+2)%N_BYTES)) +: 8] ^ m, j % 8);
         lh_aes_sbox u_sbox (
            .a (sin),
            .y (res[8*(N_BYTES-1-j) +: 8])
         );
      end
   end

   assign round_out   = g_rnd[RPC-1].res;
   assign final_round = (state == S_RUN) && ((cnt + CW'(RPC)) == CW'(ROUNDS));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      accept     = 1'b0;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      out_digest = '0;
      busy       = 1'b1;
      case (state)
         S_IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) begin
               accept    = 1'b1;
               state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (final_round) state_nxt = last ? S_OUT : S_IDLE;
         end
         S_OUT: begin
            out_valid  = 1'b1;
            out_digest = h;
            if (out_ready) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
      if (clear) state_nxt = S_IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h    <= IV;
         m    <= '0;
         last <= 1'b0;
         cnt  <= '0;
      end else if (clear) begin
         h   <= IV;
         cnt <= '0;
      end else begin
         if (accept) begin
            m    <= in_data;
            last <= in_last;
            cnt  <= '0;
            // Loading IV here is equivalent to sourcing the first round from IV.
            if (in_first) h <= IV;
         end
         if (state == S_RUN) begin
            h   <= round_out;
            cnt <= cnt + CW'(RPC);
         end
         if (out_valid && out_ready) h <= IV;
      end
   end

endmodule
